pll_reconfig_ctrl: RTL and testbench

Sequencer for the Gowin rPLL's dynamic-divider and duty/phase inputs (IDSEL, FBDSEL, ODSEL, PSDA, DUTYDA) and its reset/lock interface.
- Brings the PLL up after system reset and applies run-time reconfiguration requests through a valid/ready handshake.
- Supervises LOCK with timeout, bounded retry, and automatic relock on lock loss.
- Sits between system control logic and the PLL primitive wrapper, in the PLL input clock domain.

---
 rtl/pll_reconfig_ctrl.sv | 158 +++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_ctrl.sv
// Bring-up, reconfiguration and lock supervision sequencer for the Gowin rPLL.
// Holds the divider/duty/phase codes and drives RESET around every (re)lock attempt.
module pll_reconfig_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 65536,
    parameter int         STABLE_CYCLES = 256,
    parameter int         MAX_RETRIES   = 3,
    parameter logic [5:0] DEF_IDSEL     = 6'd0,
    parameter logic [5:0] DEF_FBDSEL    = 6'd0,
    parameter logic [5:0] DEF_ODSEL     = 6'd0,
    parameter logic [3:0] DEF_PSDA      = 4'd0,
    parameter logic [3:0] DEF_DUTYDA    = 4'd8
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    output logic       locked,
    output logic       busy,
    output logic       err_fail,
    output logic [7:0] loss_cnt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int WW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] RETRY_MAX = TW'(MAX_RETRIES);
    localparam logic [25:0]   CFG_DEF   = {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL, DEF_PSDA, DEF_DUTYDA};

    typedef enum logic [2:0] {
        S_ASSERT_RST, S_WAIT_LOCK, S_STABLE, S_LOCKED, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [TW-1:0] retry_cnt_q, retry_cnt_d;
    logic [7:0]    loss_cnt_q, loss_cnt_d;
    logic [25:0]   cfg_q, cfg_d;
    logic [1:0]    sync_q, sync_d;
    logic          lock_s, accept;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= S_ASSERT_RST;
            rst_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            stab_cnt_q  <= '0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
            cfg_q       <= CFG_DEF;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stab_cnt_q  <= stab_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            cfg_q       <= cfg_d;
            sync_q      <= sync_d;
        end
    end

    assign lock_s = sync_q[1];
    assign accept = cfg_valid & cfg_ready;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        stab_cnt_d  = stab_cnt_q;
        retry_cnt_d = retry_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        cfg_d       = cfg_q;
        sync_d      = {sync_q[0], pll_lock};
        case (state_q)
            S_ASSERT_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d    = S_WAIT_LOCK;
                    rst_cnt_d  = '0;
                    wait_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            S_WAIT_LOCK: begin
                // lock is checked first so a lock arriving on the last timer cycle still counts
                if (lock_s) begin
                    state_d    = S_STABLE;
                    stab_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    retry_cnt_d = retry_cnt_q + TW'(1);
                    rst_cnt_d   = '0;
                    state_d     = (retry_cnt_d == RETRY_MAX) ? S_FAIL : S_ASSERT_RST;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_STABLE: begin
                // a dropout resumes the attempt's timer rather than granting a fresh window
                if (!lock_s) begin
                    state_d    = S_WAIT_LOCK;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d = S_LOCKED;
                end else begin
                    stab_cnt_d = stab_cnt_q + SW'(1);
                end
            end
            S_LOCKED: begin
                retry_cnt_d = '0;
                if (!lock_s) begin
                    if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
                    rst_cnt_d = '0;
                    state_d   = S_ASSERT_RST;
                end
            end
            S_FAIL: ;
            default: state_d = S_ASSERT_RST;
        endcase
        if (accept) begin
            cfg_d       = {cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda};
            state_d     = S_ASSERT_RST;
            rst_cnt_d   = '0;
            retry_cnt_d = '0;
            loss_cnt_d  = loss_cnt_q;
        end
    end

    assign pll_reset  = (state_q == S_ASSERT_RST) || (state_q == S_FAIL);
    assign locked     = (state_q == S_LOCKED);
    assign busy       = (state_q == S_ASSERT_RST) || (state_q == S_WAIT_LOCK) || (state_q == S_STABLE);
    assign cfg_ready  = (state_q == S_LOCKED) || (state_q == S_FAIL);
    assign err_fail   = (state_q == S_FAIL);
    assign loss_cnt   = loss_cnt_q;
    assign pll_idsel  = cfg_q[25:20];
    assign pll_fbdsel = cfg_q[19:14];
    assign pll_odsel  = cfg_q[13:8];
    assign pll_psda   = cfg_q[7:4];
    assign pll_dutyda = cfg_q[3:0];
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl with small timing parameters.
module tb_pll_reconfig_ctrl;
    logic       clkin, reset, cfg_valid, cfg_ready, pll_lock, pll_reset;
    logic       locked, busy, err_fail;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel, pll_idsel, pll_fbdsel, pll_odsel;
    logic [3:0] cfg_psda, cfg_dutyda, pll_psda, pll_dutyda;
    logic [7:0] loss_cnt;

    pll_reconfig_ctrl #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clkin(clkin), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .cfg_psda(cfg_psda), .cfg_dutyda(cfg_dutyda), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
        .pll_odsel(pll_odsel), .pll_psda(pll_psda), .pll_dutyda(pll_dutyda),
        .locked(locked), .busy(busy), .err_fail(err_fail), .loss_cnt(loss_cnt)
    );

    typedef struct {
        logic [5:0] id, fb, od;
        logic [3:0] ps, du;
    } cfg_t;
    typedef struct {
        cfg_t in;
        cfg_t exp;
    } vec_t;

    int   checks = 0, failures = 0;
    int   model_loss = 0;
    cfg_t exp_q[$];
    vec_t vecs[3];
    cfg_t defc, c;

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_sel(input string nm, input cfg_t e);
        chk({nm, "_idsel"}, int'(pll_idsel), int'(e.id));
        chk({nm, "_fbdsel"}, int'(pll_fbdsel), int'(e.fb));
        chk({nm, "_odsel"}, int'(pll_odsel), int'(e.od));
        chk({nm, "_psda"}, int'(pll_psda), int'(e.ps));
        chk({nm, "_dutyda"}, int'(pll_dutyda), int'(e.du));
    endtask

    // Called on a negedge in LOCKED/FAIL; returns on the negedge after the accepting edge.
    task automatic do_accept(input cfg_t ci, input cfg_t ce);
        cfg_t e;
        chk("acc_ready_before", int'(cfg_ready), 1);
        cfg_valid  = 1'b1;
        cfg_idsel  = ci.id;
        cfg_fbdsel = ci.fb;
        cfg_odsel  = ci.od;
        cfg_psda   = ci.ps;
        cfg_dutyda = ci.du;
        exp_q.push_back(ce);
        @(negedge clkin);
        cfg_valid = 1'b0;
        if (exp_q.size() == 0) chk("acc_queue_empty", 1, 0);
        else begin
            e = exp_q.pop_front();
            chk_sel("acc", e);
        end
        chk("acc_ready_after", int'(cfg_ready), 0);
        chk("acc_pll_reset", int'(pll_reset), 1);
        chk("acc_locked", int'(locked), 0);
        chk("acc_busy", int'(busy), 1);
        chk("acc_err_clr", int'(err_fail), 0);
    endtask

    task automatic wait_rst_fall();
        int n = 0;
        while (pll_reset && n < 30) begin
            @(negedge clkin);
            n++;
        end
        chk("rst_fall_timeout", int'(pll_reset), 0);
    endtask

    task automatic wait_locked();
        int n = 0;
        while (!locked && n < 40) begin
            @(negedge clkin);
            n++;
        end
        chk("lock_timeout", int'(locked), 1);
    endtask

    task automatic relock();
        wait_rst_fall();
        pll_lock = 1'b1;
        wait_locked();
    endtask

    // Counts negedges from now until locked, noting any reset pulse on the way.
    task automatic lock_latency(input string nm);
        int n = 0;
        int seen_rst = 0;
        while (!locked && n < 40) begin
            @(negedge clkin);
            n++;
            if (pll_reset) seen_rst = 1;
        end
        chk({nm, "_lat"}, n, 11);
        chk({nm, "_no_rst"}, seen_rst, 0);
    endtask

    function automatic int count_level(input logic lvl);
        return 0;
    endfunction

    initial begin
        int n;
        reset = 1'b0; pll_lock = 1'b0; cfg_valid = 1'b0;
        cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0; cfg_psda = '0; cfg_dutyda = '0;
        defc = '{id: 6'd0, fb: 6'd0, od: 6'd0, ps: 4'd0, du: 4'd8};
        vecs[0].in = '{id: 6'd1,  fb: 6'd0,  od: 6'd3,  ps: 4'd0,  du: 4'd8};
        vecs[1].in = '{id: 6'd5,  fb: 6'd17, od: 6'd8,  ps: 4'd3,  du: 4'd12};
        vecs[2].in = '{id: 6'd63, fb: 6'd63, od: 6'd63, ps: 4'd15, du: 4'd0};
        foreach (vecs[i]) vecs[i].exp = vecs[i].in;

        #2 reset = 1'b1;
        #1;
        chk("rst_pll_reset", int'(pll_reset), 1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ready", int'(cfg_ready), 0);
        chk("rst_err", int'(err_fail), 0);
        chk("rst_loss", int'(loss_cnt), 0);
        chk_sel("rst", defc);

        // power-up
        @(negedge clkin);
        reset = 1'b0;
        n = 0;
        while (pll_reset && n < 20) begin n++; @(negedge clkin); end
        chk("pwr_rst_len", n, 4);
        chk_sel("pwr", defc);
        pll_lock = 1'b1;
        repeat (10) @(negedge clkin);
        chk("pwr_lock_early", int'(locked), 0);
        @(negedge clkin);
        chk("pwr_lock", int'(locked), 1);
        chk("pwr_ready", int'(cfg_ready), 1);
        chk("pwr_busy", int'(busy), 0);

        // table of reconfiguration requests, each followed by a relock
        for (int i = 0; i < 3; i++) begin
            pll_lock = 1'b0;
            do_accept(vecs[i].in, vecs[i].exp);
            relock();
            chk_sel("tbl_hold", vecs[i].exp);
        end

        // timeout and retry into FAIL
        c = '{id: 6'd2, fb: 6'd4, od: 6'd5, ps: 4'd1, du: 4'd6};
        pll_lock = 1'b0;
        do_accept(c, c);
        for (int p = 0; p < 2; p++) begin
            n = 0;
            while (pll_reset && n < 20) begin n++; @(negedge clkin); end
            chk("retry_rst_len", n, 4);
            n = 0;
            while (!pll_reset && n < 200) begin n++; @(negedge clkin); end
            chk("retry_wait_len", n, 100);
        end
        chk("fail_err", int'(err_fail), 1);
        chk("fail_pll_reset", int'(pll_reset), 1);
        chk("fail_ready", int'(cfg_ready), 1);
        chk("fail_busy", int'(busy), 0);
        chk("fail_locked", int'(locked), 0);
        repeat (20) @(negedge clkin);
        chk("fail_sticky", int'(err_fail), 1);
        chk_sel("fail_sel", c);
        do_accept(vecs[1].in, vecs[1].exp);

        // lock arriving on the final timer cycle wins over the timeout
        wait_rst_fall();
        repeat (97) @(negedge clkin);
        pll_lock = 1'b1;
        lock_latency("tie");

        // one-cycle dropout while qualifying lock
        pll_lock = 1'b0;
        do_accept(vecs[0].in, vecs[0].exp);
        wait_rst_fall();
        pll_lock = 1'b1;
        repeat (5) @(negedge clkin);
        chk("glitch_stable", int'(locked), 0);
        pll_lock = 1'b0;
        @(negedge clkin);
        pll_lock = 1'b1;
        lock_latency("glitch");

        // single lock loss
        chk("loss_init", int'(loss_cnt), 0);
        pll_lock = 1'b0;
        n = 0;
        while (locked && n < 10) begin @(negedge clkin); n++; end
        model_loss++;
        chk("loss_fall_lat", n, 3);
        chk("loss_cnt1", int'(loss_cnt), model_loss);
        chk("loss_pll_reset", int'(pll_reset), 1);
        relock();

        // request accepted on the same edge that sees lock lost
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin);
        do_accept(vecs[2].in, vecs[2].exp);
        chk("simul_loss_hold", int'(loss_cnt), model_loss);
        relock();

        // saturation after 300 total losses
        for (int k = 0; k < 299; k++) begin
            pll_lock = 1'b0;
            n = 0;
            while (locked && n < 10) begin @(negedge clkin); n++; end
            if (model_loss < 255) model_loss++;
            if (k % 60 == 0) chk("loss_cnt_run", int'(loss_cnt), model_loss);
            relock();
        end
        chk("loss_sat", int'(loss_cnt), 255);

        // asynchronous reset in WAIT_LOCK reverts config
        c = '{id: 6'd1, fb: 6'd0, od: 6'd3, ps: 4'd0, du: 4'd8};
        pll_lock = 1'b0;
        do_accept(c, c);
        wait_rst_fall();
        repeat (3) @(negedge clkin);
        chk("mid_odsel_pre", int'(pll_odsel), 3);
        #2 reset = 1'b1;
        #1;
        chk("async_odsel", int'(pll_odsel), 0);
        chk("async_pll_reset", int'(pll_reset), 1);
        chk("async_locked", int'(locked), 0);
        chk("async_loss", int'(loss_cnt), 0);
        chk_sel("async", defc);
        @(negedge clkin);
        reset = 1'b0;
        repeat (2) @(negedge clkin);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
